rf_access_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one variable-store access port among NUM_REQ requesters. The store is the reflection backdoor that gets and sets variables by index.
- Each requester issues a single get or set. The block grants one requester, issues the transaction to the store, waits for completion with a timeout, and routes the response back to the granted requester.
- Sits between the debug/test agents and the variable store.

---
 rtl/rf_access_arbiter.sv | 144 ++++++++++++++
 tb/tb_rf_access_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing one variable-store port among NUM_REQ get/set requesters.
// Accept-to-response is 3 cycles best case; store backpressure stalls ISSUE, WAIT times out after TIMEOUT cycles.
module rf_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*IDX_W-1:0]    req_idx,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        st_valid,
  input  logic                        st_ready,
  output logic                        st_write,
  output logic [IDX_W-1:0]            st_idx,
  output logic [DATA_W-1:0]           st_wdata,
  input  logic                        st_rsp_valid,
  input  logic [DATA_W-1:0]           st_rsp_rdata,
  input  logic                        st_rsp_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [PTR_W-1:0]    w_gnt_id;
  logic                w_gnt_any;
  logic                r_write;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [15:0]         r_cnt;
  logic                w_accept;
  logic                w_timeout;

  // Scan downward so the lowest offset from the pointer is written last and wins.
  always_comb begin
    int c;
    c         = 0;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(r_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req_valid[c]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = PTR_W'(c);
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_gnt_any;
  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    st_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_any) begin
          req_ready[w_gnt_id] = 1'b1;
          w_next              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        st_valid = 1'b1;
        if (st_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (st_rsp_valid || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid[r_owner] = 1'b1;
        w_next             = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_gnt_id;
        r_write <= req_write[w_gnt_id];
        r_idx   <= req_idx[w_gnt_id*IDX_W +: IDX_W];
        r_wdata <= req_wdata[w_gnt_id*DATA_W +: DATA_W];
      end
      if (r_state == S_ISSUE && st_ready) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 16'd1;
      end
      // A store response in the timeout cycle takes precedence over the timeout.
      if (r_state == S_WAIT) begin
        if (st_rsp_valid) begin
          r_rdata <= r_write ? '0 : st_rsp_rdata;
          r_err   <= st_rsp_err;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == S_RESP) begin
        r_ptr <= (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign st_write  = r_write;
  assign st_idx    = r_idx;
  assign st_wdata  = r_wdata;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Randomized bench for rf_access_arbiter: drives requesters and acts as the store,
// comparing against a transaction-level round-robin/timeout model.
module tb_rf_access_arbiter;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*IW-1:0] req_idx;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, st_wdata, st_rsp_rdata;
  logic            rsp_err, st_valid, st_ready, st_write, st_rsp_valid, st_rsp_err;
  logic [IW-1:0]   st_idx;

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = 0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err   = 1'b0;

  rf_access_arbiter #(.NUM_REQ(N), .IDX_W(IW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_idx(req_idx), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .st_valid(st_valid), .st_ready(st_ready), .st_write(st_write),
    .st_idx(st_idx), .st_wdata(st_wdata),
    .st_rsp_valid(st_rsp_valid), .st_rsp_rdata(st_rsp_rdata), .st_rsp_err(st_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    req_write = N'($urandom);
    req_idx   = N*IW'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One full transaction. d = WAIT cycle carrying the store pulse; d > TO means the store stays silent.
  task automatic do_op(input logic [N-1:0] vmask, input logic [N-1:0] wr,
                       input logic [N*IW-1:0] idxs, input logic [N*DW-1:0] wds,
                       input int stall, input int d, input logic [DW-1:0] sdata,
                       input logic serr, input bit late);
    int g;
    int last;
    logic [N-1:0] exp_rdy;
    g = rr_pick(m_ptr, vmask);
    exp_rdy = '0;
    exp_rdy[g] = 1'b1;
    req_valid = vmask;
    req_write = wr;
    req_idx   = idxs;
    req_wdata = wds;
    @(negedge clk);
    chk("grant", req_ready, exp_rdy);
    chk("idle_rsp_quiet", rsp_valid, '0);
    chk("rsp_hold", {rsp_err, rsp_rdata}, {m_err, m_rdata});
    step();
    scramble();
    for (int s = 0; s <= stall; s++) begin
      st_ready = (s == stall);
      @(negedge clk);
      chk("st_valid", st_valid, 1'b1);
      chk("st_fields", {st_write, st_idx, st_wdata}, {wr[g], idxs[g*IW +: IW], wds[g*DW +: DW]});
      step();
    end
    st_ready = 1'b0;
    last = (d < TO) ? d : TO;
    for (int j = 1; j <= last; j++) begin
      st_rsp_valid = (j == d);
      st_rsp_rdata = (j == d) ? sdata : DW'($urandom);
      st_rsp_err   = (j == d) ? serr : 1'b0;
      @(negedge clk);
      chk("wait_quiet", {st_valid, rsp_valid}, '0);
      step();
    end
    st_rsp_valid = 1'b0;
    if (d <= TO) begin
      m_rdata = wr[g] ? '0 : sdata;
      m_err   = serr;
    end else begin
      m_rdata = '0;
      m_err   = 1'b1;
    end
    @(negedge clk);
    chk("rsp_valid", rsp_valid, exp_rdy);
    chk("rsp_data", {rsp_err, rsp_rdata}, {m_err, m_rdata});
    chk("no_accept_in_resp", req_ready, '0);
    m_ptr = (g + 1) % N;
    if (late) begin
      req_valid = '0;
      step();
      step();
      step();
      st_rsp_valid = 1'b1;
      st_rsp_rdata = 32'h5A5A_A5A5;
      st_rsp_err   = 1'b0;
      @(negedge clk);
      chk("late_ignored", rsp_valid, '0);
      step();
      st_rsp_valid = 1'b0;
      @(negedge clk);
      chk("late_no_effect", {st_valid, rsp_valid, rsp_err, rsp_rdata}, {5'b0, m_err, m_rdata});
    end
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N*IW-1:0] ix;
    logic [N*DW-1:0] wd;
    int d;
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_idx = '0; req_wdata = '0;
    st_ready = 1'b0; st_rsp_valid = 1'b0; st_rsp_rdata = '0; st_rsp_err = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, st_valid, st_write, st_idx, st_wdata},
        '0);
    step();
    rst = 1'b0;

    ix = '0; ix[2*IW +: IW] = 8'h11;
    do_op(4'b0100, 4'b0000, ix, '0, 0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      do_op(4'b1111, 4'b0000, N*IW'($urandom), '0, 0, 1, $urandom, 1'b0, 1'b0);

    ix = '0; ix[1*IW +: IW] = 8'h05;
    wd = '0; wd[1*DW +: DW] = 32'h0000_1234;
    do_op(4'b0010, 4'b0010, ix, wd, 10, 1, 32'hFFFF_0000, 1'b0, 1'b0);

    do_op(4'b1000, 4'b0000, 32'h0700_0000, '0, 0, TO + 5, 32'h1111_1111, 1'b0, 1'b1);
    do_op(4'b1000, 4'b0000, 32'h0800_0000, '0, 1, 3, 32'h2222_2222, 1'b0, 1'b0);
    do_op(4'b0001, 4'b0000, 32'h0000_0099, '0, 0, 1, 32'h3333_3333, 1'b1, 1'b0);
    do_op(4'b0001, 4'b0000, 32'h0000_0042, '0, 0, TO, 32'hCAFE_F00D, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      d = $urandom_range(1, TO + 2);
      do_op(N'($urandom_range(1, 15)), N'($urandom), N*IW'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), d,
            $urandom, ($urandom_range(0, 3) == 0), (d > TO) && $urandom_range(0, 1) == 1);
    end

    // Reset during a pending get: owner 2 would hand priority to 3, reset must return it to 0.
    req_valid = '0;
    do_op(4'b0001, 4'b0000, 32'h0000_0010, '0, 0, 1, 32'h7777_7777, 1'b1, 1'b0);
    req_valid = 4'b0100;
    req_write = '0;
    req_idx = 32'h0033_0000;
    @(negedge clk);
    chk("rst_pre_grant", req_ready, 4'b0100);
    step();
    st_ready = 1'b1;
    step();
    st_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_mid_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, st_valid, st_write, st_idx, st_wdata},
        '0);
    for (int i = 0; i < TO + 2; i++) begin
      st_rsp_valid = (i == 1);
      st_rsp_rdata = 32'h4444_4444;
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, '0);
      step();
    end
    st_rsp_valid = 1'b0;
    m_ptr = 0;
    m_rdata = '0;
    m_err = 1'b0;
    do_op(4'b1111, 4'b0000, N*IW'($urandom), '0, 0, 1, 32'h5555_5555, 1'b0, 1'b0);

    req_valid = '0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
